// File: rtl/reg_file.sv
// reg_file: integer register file at the writeback end of the pipeline.
// Two combinational read ports with same-cycle write bypass, a pending-write
// scoreboard for hazard detection, and a post-reset sweep that clears the
// array one entry per cycle while init_busy stalls the pipeline.
module reg_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rf_we,
    input  logic [4:0]      rf_waddr,
    input  logic [XLEN-1:0] rf_wdata,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            sb_set,
    input  logic [4:0]      sb_set_addr,
    input  logic            sb_flush,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            init_busy
);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Highest architectural register; also the terminal sweep index.
    localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);

    state_t           state_q, state_d;
    logic [4:0]       idx_q, idx_d;
    logic [NREGS-1:0] pend_q, pend_d;
    logic [XLEN-1:0]  mem_q [0:NREGS-1];

    logic             mem_we_s;
    logic [4:0]       mem_waddr_s;
    logic [XLEN-1:0]  mem_wdata_s;

    // Sweep FSM next state and selection of the single array write port.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = rf_waddr;
        mem_wdata_s = rf_wdata;
        case (state_q)
            ST_INIT: begin
                // WB writes are ignored while the sweep owns the write port.
                mem_we_s    = 1'b1;
                mem_waddr_s = idx_q;
                mem_wdata_s = '0;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_READY;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            ST_READY: begin
                mem_we_s = rf_we && (rf_waddr != 5'd0);
            end
            default: begin
                state_d = ST_INIT;
                idx_d   = 5'd1;
            end
        endcase
    end

    // Scoreboard next state: set beats flush, flush beats writeback clear.
    always_comb begin
        pend_d = pend_q;
        if (state_q == ST_READY) begin
            for (int r = 1; r < NREGS; r++) begin
                if (sb_set && (sb_set_addr == 5'(r))) begin
                    pend_d[r] = 1'b1;
                end else if (sb_flush) begin
                    pend_d[r] = 1'b0;
                end else if (rf_we && (rf_waddr == 5'(r))) begin
                    pend_d[r] = 1'b0;
                end else begin
                    pend_d[r] = pend_q[r];
                end
            end
        end else begin
            pend_d = pend_q;
        end
        pend_d[0] = 1'b0;
    end

    // Control state: FSM, sweep index and pending vector with sync reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            idx_q   <= 5'd1;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
        end
    end

    // RAM-style array; no reset, contents are cleared by the sweep instead.
    always_ff @(posedge clk) begin
        if (mem_we_s && (mem_waddr_s <= LAST_IDX)) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Read ports with write bypass; x0 and the sweep phase read as zero.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if ((state_q == ST_READY) && (rs1_addr != 5'd0) && (rs1_addr <= LAST_IDX)) begin
            if (rf_we && (rf_waddr == rs1_addr)) begin
                rs1_data = rf_wdata;
            end else begin
                rs1_data = mem_q[rs1_addr];
            end
        end else begin
            rs1_data = '0;
        end
        if ((state_q == ST_READY) && (rs2_addr != 5'd0) && (rs2_addr <= LAST_IDX)) begin
            if (rf_we && (rf_waddr == rs2_addr)) begin
                rs2_data = rf_wdata;
            end else begin
                rs2_data = mem_q[rs2_addr];
            end
        end else begin
            rs2_data = '0;
        end
    end

    // Busy flags; a register written this cycle is served by the bypass.
    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        if ((state_q == ST_READY) && (rs1_addr != 5'd0)) begin
            rs1_busy = pend_q[rs1_addr] && !(rf_we && (rf_waddr == rs1_addr));
        end else begin
            rs1_busy = 1'b0;
        end
        if ((state_q == ST_READY) && (rs2_addr != 5'd0)) begin
            rs2_busy = pend_q[rs2_addr] && !(rf_we && (rf_waddr == rs2_addr));
        end else begin
            rs2_busy = 1'b0;
        end
    end

    assign init_busy = (state_q == ST_INIT);

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed plus randomized checks of reg_file against a
// behavioural model (register array, pending flags, sweep countdown).
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst, rf_we, sb_set, sb_flush;
    logic [4:0]  rf_waddr, rs1_addr, rs2_addr, sb_set_addr;
    logic [31:0] rf_wdata, rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy, init_busy;

    int total = 0;
    int bad   = 0;

    // Behavioural model
    logic [31:0] m_mem [32];
    bit          m_pend [32];
    bit          m_ready = 1'b0;
    int          m_left  = 0;
    bit          m_valid = 1'b0;

    // Last sampled DUT outputs
    logic [31:0] o_r1d, o_r2d;
    logic        o_r1b, o_r2b, o_ib;

    always #5 clk = ~clk;

    reg_file #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .rst(rst),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .sb_set(sb_set), .sb_set_addr(sb_set_addr), .sb_flush(sb_flush),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .init_busy(init_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (!m_ready || a == 5'd0) return 32'd0;
        if (rf_we && rf_waddr == a) return rf_wdata;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        return m_ready && (a != 5'd0) && m_pend[a] && !(rf_we && rf_waddr == a);
    endfunction

    // One clock cycle: drive, compare against the model, clock, advance model.
    task automatic cyc(input logic r_in, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                       input logic st, input logic [4:0] sa, input logic fl);
        bit np [32];
        rst = r_in; rf_we = we; rf_waddr = wa; rf_wdata = wd;
        rs1_addr = a1; rs2_addr = a2; sb_set = st; sb_set_addr = sa; sb_flush = fl;
        #1;
        o_r1d = rs1_data; o_r2d = rs2_data;
        o_r1b = rs1_busy; o_r2b = rs2_busy; o_ib = init_busy;
        if (m_valid) begin
            check("rs1_data", o_r1d, exp_data(a1));
            check("rs2_data", o_r2d, exp_data(a2));
            check("rs1_busy", 32'(o_r1b), 32'(exp_busy(a1)));
            check("rs2_busy", 32'(o_r2b), 32'(exp_busy(a2)));
            check("init_busy", 32'(o_ib), 32'(!m_ready));
        end
        @(posedge clk);
        if (r_in) begin
            m_valid = 1'b1;
            m_ready = 1'b0;
            m_left  = 31;
            for (int k = 0; k < 32; k++) m_pend[k] = 1'b0;
        end else if (!m_ready) begin
            m_left--;
            if (m_left == 0) begin
                m_ready = 1'b1;
                for (int k = 0; k < 32; k++) m_mem[k] = 32'd0;
            end
        end else begin
            np[0] = 1'b0;
            for (int k = 1; k < 32; k++) begin
                if (st && sa == 5'(k))      np[k] = 1'b1;
                else if (fl)                np[k] = 1'b0;
                else if (we && wa == 5'(k)) np[k] = 1'b0;
                else                        np[k] = m_pend[k];
            end
            for (int k = 0; k < 32; k++) m_pend[k] = np[k];
            if (we && wa != 5'd0) m_mem[wa] = wd;
        end
        #1;
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, a1, a2, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        int cnt;
        // Reset held three cycles
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);

        // Sweep length, with a dropped write of x5 while sweeping
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, (i < 30), 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
            if (o_ib) cnt++;
            else break;
        end
        check("sweep_len", 32'(cnt), 32'd31);
        idle(5'd5, 5'd0);
        check("x5_after_init", o_r1d, 32'd0);

        // Write / bypass / x0
        cyc(1'b0, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
        check("bypass_x7", o_r1d, 32'h12345678);
        idle(5'd7, 5'd7);
        check("array_x7", o_r2d, 32'h12345678);
        cyc(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        check("x0_write_read", o_r2d, 32'd0);
        idle(5'd0, 5'd0);
        check("x0_after", o_r2d, 32'd0);

        // Scoreboard set then writeback clear
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd0, 1'b1, 5'd10, 1'b0);
        idle(5'd10, 5'd0);
        check("sb_set_x10", 32'(o_r1b), 32'd1);
        cyc(1'b0, 1'b1, 5'd10, 32'hA5A5A5A5, 5'd10, 5'd0, 1'b0, 5'd0, 1'b0);
        check("wb_clear_busy", 32'(o_r1b), 32'd0);
        check("wb_clear_data", o_r1d, 32'hA5A5A5A5);
        idle(5'd10, 5'd10);
        check("x10_pending_gone", 32'(o_r2b), 32'd0);

        // Set/clear collision on x3
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd3, 1'b1, 5'd3, 1'b0);
        idle(5'd0, 5'd3);
        check("x3_pending", 32'(o_r2b), 32'd1);
        cyc(1'b0, 1'b1, 5'd3, 32'h00000033, 5'd0, 5'd3, 1'b1, 5'd3, 1'b0);
        check("x3_bypass_not_busy", 32'(o_r2b), 32'd0);
        idle(5'd0, 5'd3);
        check("x3_set_beats_clear", 32'(o_r2b), 32'd1);

        // Flush with a simultaneous set
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd1, 1'b0);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd2, 1'b0);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd31, 1'b1, 5'd31, 1'b0);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 1'b1, 5'd4, 1'b1);
        idle(5'd1, 5'd2);
        check("flush_x1", 32'(o_r1b), 32'd0);
        check("flush_x2", 32'(o_r2b), 32'd0);
        idle(5'd31, 5'd4);
        check("flush_x31", 32'(o_r1b), 32'd0);
        check("flush_set_x4", 32'(o_r2b), 32'd1);
        idle(5'd0, 5'd3);
        check("x0_never_busy", 32'(o_r1b), 32'd0);
        check("flush_x3", 32'(o_r2b), 32'd0);

        // Reset mid-sweep
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 15; i++) idle(5'd7, 5'd4);
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            idle(5'd4, 5'd7);
            if (o_ib) cnt++;
            else break;
        end
        check("sweep_len_restart", 32'(cnt), 32'd31);
        idle(5'd4, 5'd7);
        check("x4_cleared_by_reset", 32'(o_r1b), 32'd0);
        check("x7_cleared_by_sweep", o_r2d, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [4:0] a1, a2;
            a1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 7));
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
                a1, a2,
                ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                ($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Integer register file at the writeback end of the CPU pipeline. It consumes the WB stage's write port (`rf_we`/`rf_waddr`/`rf_wdata`) and serves two combinational read ports to decode, with same-cycle write bypass. It also holds a pending-write scoreboard for hazard detection and runs a post-reset clear sweep over a RAM-style array, one entry per cycle.

## Interface
Parameters:
- XLEN, 32, data width
- NREGS, 32, architectural register count; the address width is fixed at 5 bits

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous and active-high
- rf_we  in  1  write enable from WB; already qualified by WB with valid and rd≠0
- rf_waddr  in  5  write address
- rf_wdata  in  XLEN  write data
- rs1_addr  in  5  read port 1 address
- rs2_addr  in  5  read port 2 address
- rs1_data  out  XLEN  read port 1 data (combinational)
- rs2_data  out  XLEN  read port 2 data (combinational)
- sb_set  in  1  issue marks a destination register as pending
- sb_set_addr  in  5  register to mark pending
- sb_flush  in  1  clear all pending bits (pipeline flush)
- rs1_busy  out  1  rs1 has an outstanding write not yet available
- rs2_busy  out  1  rs2 has an outstanding write not yet available
- init_busy  out  1  clear sweep in progress; the pipeline must stall

## Operation
- **State machine:** two states, INIT and READY.
  - rst forces INIT, sweep index = 1, pending vector = 0.
  - INIT: each cycle writes 0 to entry[idx] and increments idx. When idx = NREGS-1 is written, the next state is READY.
  - READY: normal operation. It stays in READY until rst.
- **Writes in INIT:** rf_we is ignored. In READY, rf_we with rf_waddr≠0 writes entry[rf_waddr] at the edge.
- **x0:** never stored. Writes to it are dropped, reads return 0, and it is never busy.
- **Reads:**
  - rsN_data = 0 if rsN_addr = 0 or state = INIT.
  - Otherwise it returns rf_wdata if rf_we and rf_waddr = rsN_addr (bypass).
  - Otherwise it returns entry[rsN_addr].
- **Scoreboard:** pending[NREGS-1:1], reset 0; updates are accepted in READY only. Per-edge priority, highest first:
  - sb_set with sb_set_addr≠0 sets that bit. Set beats a same-address clear, because it represents a newer producer.
  - sb_flush clears all bits not being set.
  - rf_we clears pending[rf_waddr].
- **Busy outputs:** rsN_busy = pending[rsN_addr] AND NOT (rf_we AND rf_waddr = rsN_addr). This holds for rsN_addr≠0 and is 0 in INIT. A register being written this cycle is not busy, because the bypass supplies its value.
- **Both ports on one address:** both return identical data and busy.
- **Arithmetic:** the sweep index is 5 bits and never wraps; the terminal value NREGS-1 ends the sweep.

## Timing
- **Reset values:**
  - init_busy = 1.
  - rs1_data/rs2_data = 0 (INIT forces 0).
  - rs1_busy/rs2_busy = 0.
  - Array contents after the sweep are all 0.
- **Sweep length:** init_busy stays high for exactly NREGS-1 = 31 cycles after the first edge with rst low. It drops in the cycle after entry 31 is written.
- **Read latency:** 0 cycles (combinational).
- **Write latency:** a write is visible via bypass in the same cycle and from the array on the next cycle.
- **Scoreboard timing:**
  - A set is visible on busy in the cycle after sb_set.
  - A clear removes busy in the same cycle, via the rf_we term.
  - The pending bit itself falls at the edge.
- **Reset mid-sweep or mid-operation:** the sweep restarts at idx 1, the pending vector clears, and init_busy reasserts in the cycle after the rst edge.

## Test plan
- **Reset sweep:** hold rst 3 cycles, release, and count init_busy high cycles → exactly 31. rs1_addr=5 reads 0 throughout. Write x5=0xDEADBEEF during INIT → dropped, and x5 reads 0 after READY.
- **Write/read/bypass:**
  - Write x7=0x12345678. Same cycle with rs1_addr=7 → rs1_data=0x12345678.
  - Next cycle with no write → still 0x12345678.
  - Write x0=0xFFFFFFFF → rs2_addr=0 reads 0.
- **Scoreboard basic:**
  - sb_set x10 → rs1_busy=1 from the next cycle.
  - rf_we x10 with data 0xA5A5A5A5 → rs1_busy=0 and rs1_data=0xA5A5A5A5 in the same cycle.
  - Pending bit is 0 afterwards.
- **Set/clear collision:** pending x3 is already set; same cycle assert sb_set x3 and rf_we x3 → next cycle rs2_busy(x3)=1.
- **Flush:** set x1, x2, x31; then sb_flush with sb_set x4 in the same cycle → next cycle only x4 busy. rs1_addr=0 is never busy.
- **Reset mid-sweep:** assert rst at sweep cycle 15 for 1 cycle → init_busy high 31 more cycles and pending all 0.
